// File: rtl/riscv_pkg.sv
// Shared register-file constants, instruction field positions and the
// write-back entry type used by the write-side controller and its load buffer.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic [REG_ADDR_W-1:0] instr_field(
        input logic [31:0] instr,
        input int          lsb
    );
        return instr[lsb +: REG_ADDR_W];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer of write-back entries with full/empty flags.
// Pushes while full and pops while empty are ignored.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: storage carries no reset; only the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Owns the register file write port: ALU results win, buffered loads fill idle
// cycles, and a pending-destination scoreboard stalls issue on RAW/WAW hazards.
module reg_writeback_ctrl #(
    parameter int XLEN     = 32,
    parameter int LD_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [31:0]     issue_instr,
    input  logic            issue_wr,
    output logic            stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            reg_wr_en,
    output logic [4:0]      wr_reg,
    output logic [XLEN-1:0] wr_data,
    output logic            busy
);

    import riscv_pkg::*;

    if (XLEN != riscv_pkg::XLEN) begin : g_xlen_check
        $error("reg_writeback_ctrl: XLEN must match riscv_pkg::XLEN");
    end

    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [NUM_REGS-1:0]   set_mask, clr_mask;
    logic                  issue_fire;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_reg_q;
    logic [XLEN-1:0]       wr_data_q;

    wb_entry_t             ld_entry, ld_head, sel;
    logic                  sel_valid;
    logic                  fifo_full, fifo_empty, ld_push, ld_pop;

    logic                  unused_instr_bits;

    assign rd  = instr_field(issue_instr, RD_LSB);
    assign rs1 = instr_field(issue_instr, RS1_LSB);
    assign rs2 = instr_field(issue_instr, RS2_LSB);
    assign unused_instr_bits = ^{issue_instr[31:25], issue_instr[14:12], issue_instr[6:0]};

    assign stall = issue_valid
                 & (pending_q[rs1] | pending_q[rs2] | (issue_wr & pending_q[rd]));
    assign issue_fire = issue_valid & ~stall;

    // Loads are only drained on cycles the ALU leaves the write port free.
    assign ld_entry = '{rd: ld_rd, data: ld_data};
    assign ld_ready = ~fifo_full;
    assign ld_push  = ld_valid & ~fifo_full;
    assign ld_pop   = ~alu_valid & ~fifo_empty;

    wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (ld_push),
        .push_entry_i (ld_entry),
        .pop_i        (ld_pop),
        .head_o       (ld_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel       = ld_head;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel       = '{rd: alu_rd, data: alu_data};
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
        end
    end

    // Set is applied after clear so a same-index set wins; x0 never goes pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_fire && issue_wr) begin
            set_mask[rd] = 1'b1;
        end
        if (sel_valid) begin
            clr_mask[sel.rd] = 1'b1;
        end
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    assign wr_en_d = sel_valid && (sel.rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            pending_q <= pending_d;
            wr_en_q   <= wr_en_d;
            if (wr_en_d) begin
                wr_reg_q  <= sel.rd;
                wr_data_q <= sel.data;
            end
        end
    end

    assign reg_wr_en = wr_en_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;
    assign busy      = (|pending_q) | ~fifo_empty;

endmodule
